// File: rtl/instr_predecode_queue_pkg.sv
// Shared RV32 instruction types plus the predecoded queue entry.
// Field values follow the RV32I/M/F base opcode map.
package INSTRUCTION_TYPE;

  typedef enum logic [6:0] {
    LOAD    = 7'b0000011,
    FLOAD   = 7'b0000111,
    FENCE_O = 7'b0001111,
    ALU_I   = 7'b0010011,
    AUIPC   = 7'b0010111,
    STORE   = 7'b0100011,
    FSTORE  = 7'b0100111,
    REG_OP  = 7'b0110011,
    LUI     = 7'b0110111,
    FMADD   = 7'b1000011,
    FMSUB   = 7'b1000111,
    FNMSUB  = 7'b1001011,
    FNMADD  = 7'b1001111,
    F_OPS   = 7'b1010011,
    BRANCH  = 7'b1100011,
    JALR    = 7'b1100111,
    JAL     = 7'b1101111,
    ECSR    = 7'b1110011
  } opcode_e;

  localparam logic [6:0] A_F7_I = 7'b0000000;
  localparam logic [6:0] B_F7_I = 7'b0100000;
  localparam logic [6:0] F7_M   = 7'b0000001;

  localparam logic [2:0] SUM = 3'b000;
  localparam logic [2:0] SR  = 3'b101;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_t;

  typedef enum logic [3:0] {
    CLS_ALU     = 4'd0,
    CLS_MULDIV  = 4'd1,
    CLS_BRANCH  = 4'd2,
    CLS_JUMP    = 4'd3,
    CLS_LOAD    = 4'd4,
    CLS_STORE   = 4'd5,
    CLS_SYSTEM  = 4'd6,
    CLS_FMEM    = 4'd7,
    CLS_FPU     = 4'd8,
    CLS_ILLEGAL = 4'd9
  } dec_class_e;

  typedef struct packed {
    instruction_t instr;
    logic [31:0]  pc;
    logic [31:0]  imm;
    dec_class_e   cls;
    logic         illegal;
  } predec_entry_t;

  // The four fused multiply-add forms plus the generic OP-FP major opcode.
  function automatic logic is_fp_arith(logic [6:0] op);
    return (op == FMADD) || (op == FMSUB) || (op == FNMSUB) ||
           (op == FNMADD) || (op == F_OPS);
  endfunction

endpackage

// File: rtl/instr_predecode_queue_if.sv
// Fetch-to-decode handshake bundle of the predecode queue.
interface instr_predecode_queue_if
  import INSTRUCTION_TYPE::*;
;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  instruction_t fetch_instr_i;
  logic [31:0]  fetch_pc_i;

  logic         dec_valid_o;
  logic         dec_ready_i;
  instruction_t dec_instr_o;
  logic [31:0]  dec_pc_o;
  logic [31:0]  dec_imm_o;
  dec_class_e   dec_class_o;
  logic         dec_illegal_o;

  modport slave (
    input  fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
    output fetch_ready_o, dec_valid_o, dec_instr_o, dec_pc_o,
           dec_imm_o, dec_class_o, dec_illegal_o
  );

  modport master (
    output fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
    input  fetch_ready_o, dec_valid_o, dec_instr_o, dec_pc_o,
           dec_imm_o, dec_class_o, dec_illegal_o
  );

endinterface

// File: rtl/instr_predecode_queue_predecoder.sv
// Combinational RV32 predecoder: class, legality and sign-extended immediate.
module instr_predecoder
  import INSTRUCTION_TYPE::*;
#(
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_F = 1'b1
) (
  input  instruction_t  instr_i,
  input  logic [31:0]   pc_i,
  output predec_entry_t entry_o
);

  logic [31:0] w;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] imm;
  dec_class_e  cls;

  assign w     = instr_i;
  assign imm_i = {{20{w[31]}}, w[31:20]};
  assign imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
  assign imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
  assign imm_u = {w[31:12], 12'b0};
  assign imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};

  // Immediate depends only on the major opcode; legality only affects class.
  always_comb begin
    cls = CLS_ILLEGAL;
    imm = '0;
    case (instr_i.opcode)
      LUI, AUIPC: begin cls = CLS_ALU;    imm = imm_u; end
      ALU_I:      begin cls = CLS_ALU;    imm = imm_i; end
      BRANCH:     begin cls = CLS_BRANCH; imm = imm_b; end
      JAL:        begin cls = CLS_JUMP;   imm = imm_j; end
      JALR:       begin cls = CLS_JUMP;   imm = imm_i; end
      LOAD:       begin cls = CLS_LOAD;   imm = imm_i; end
      STORE:      begin cls = CLS_STORE;  imm = imm_s; end
      FENCE_O,
      ECSR:       begin cls = CLS_SYSTEM; imm = imm_i; end
      FLOAD: begin
        imm = imm_i;
        if (ENABLE_F) cls = CLS_FMEM;
      end
      FSTORE: begin
        imm = imm_s;
        if (ENABLE_F) cls = CLS_FMEM;
      end
      REG_OP: begin
        case (instr_i.funct7)
          A_F7_I: cls = CLS_ALU;
          // The alternate funct7 only encodes SUB and SRA.
          B_F7_I: if (instr_i.funct3 == SUM || instr_i.funct3 == SR) cls = CLS_ALU;
          F7_M:   if (ENABLE_M) cls = CLS_MULDIV;
          default: ;
        endcase
      end
      default: if (ENABLE_F && is_fp_arith(instr_i.opcode)) cls = CLS_FPU;
    endcase
  end

  assign entry_o.instr   = instr_i;
  assign entry_o.pc      = pc_i;
  assign entry_o.imm     = imm;
  assign entry_o.cls     = cls;
  assign entry_o.illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/instr_predecode_queue.sv
// Fetch-to-decode FIFO that stores each instruction with its predecode result.
// Head is registered storage: an entry is visible the cycle after its push.
module instr_predecode_queue
  import INSTRUCTION_TYPE::*;
#(
  parameter int DEPTH    = 4,
  parameter bit ENABLE_M = 1'b1,
  parameter bit ENABLE_F = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  instr_predecode_queue_if.slave     bus,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  predec_entry_t    pd_entry;
  predec_entry_t    head;
  predec_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             full, empty, push, pop;

  instr_predecoder #(
    .ENABLE_M (ENABLE_M),
    .ENABLE_F (ENABLE_F)
  ) u_predec (
    .instr_i (bus.fetch_instr_i),
    .pc_i    (bus.fetch_pc_i),
    .entry_o (pd_entry)
  );

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // Full blocks a push even when a pop frees a slot in the same cycle.
  assign push  = bus.fetch_valid_i && !full && !flush_i;
  assign pop   = !empty && bus.dec_ready_i && !flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr] <= pd_entry;
  end

  assign head = mem[rd_ptr];

  assign bus.fetch_ready_o = !full;
  assign bus.dec_valid_o   = !empty;
  assign bus.dec_instr_o   = head.instr;
  assign bus.dec_pc_o      = head.pc;
  assign bus.dec_imm_o     = head.imm;
  assign bus.dec_class_o   = head.cls;
  assign bus.dec_illegal_o = head.illegal;
  assign count_o           = count_q;

endmodule

// File: tb/tb_instr_predecode_queue.sv
// Scoreboard bench: offers push hand-computed expectations, monitors pop and compare.
module tb_instr_predecode_queue;
  import INSTRUCTION_TYPE::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        ill;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic [2:0] cnt0, cnt1;
  int         passed = 0;
  int         total  = 0;
  exp_t       exp0[$];
  exp_t       exp1[$];

  always #5 clk = ~clk;

  instr_predecode_queue_if q0();
  instr_predecode_queue_if q1();

  instr_predecode_queue #(.DEPTH(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(q0.slave), .count_o(cnt0)
  );

  instr_predecode_queue #(.DEPTH(4), .ENABLE_M(1'b0), .ENABLE_F(1'b0)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(q1.slave), .count_o(cnt1)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  task automatic cmp_head(string tag, exp_t e, logic [31:0] instr, logic [31:0] pc,
                          logic [31:0] imm, logic [3:0] cls, logic ill);
    chk({tag, " instr"}, instr, e.instr);
    chk({tag, " pc"}, pc, e.pc);
    chk({tag, " imm"}, imm, e.imm);
    chk({tag, " class"}, 32'(cls), 32'(e.cls));
    chk({tag, " illegal"}, 32'(ill), 32'(e.ill));
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && !flush && q0.dec_valid_o && q0.dec_ready_i) begin
      if (exp0.size() == 0) chk("dut0 unexpected pop", 32'(q0.dec_pc_o), 32'hFFFF_FFFF);
      else begin
        e = exp0.pop_front();
        cmp_head("dut0", e, q0.dec_instr_o, q0.dec_pc_o, q0.dec_imm_o,
                 q0.dec_class_o, q0.dec_illegal_o);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && !flush && q1.dec_valid_o && q1.dec_ready_i) begin
      if (exp1.size() == 0) chk("dut1 unexpected pop", 32'(q1.dec_pc_o), 32'hFFFF_FFFF);
      else begin
        e = exp1.pop_front();
        cmp_head("dut1", e, q1.dec_instr_o, q1.dec_pc_o, q1.dec_imm_o,
                 q1.dec_class_o, q1.dec_illegal_o);
      end
    end
  end

  // Called just after a rising edge; holds the offer for exactly one cycle.
  task automatic offer(int w, logic [31:0] instr, logic [31:0] pc, logic [31:0] imm,
                       logic [3:0] cls, logic ill, bit acc);
    exp_t e;
    e = '{instr, pc, imm, cls, ill};
    if (w == 0) begin
      q0.fetch_valid_i = 1'b1; q0.fetch_instr_i = instr; q0.fetch_pc_i = pc;
    end else begin
      q1.fetch_valid_i = 1'b1; q1.fetch_instr_i = instr; q1.fetch_pc_i = pc;
    end
    @(negedge clk);
    chk("fetch_ready", 32'(w == 0 ? q0.fetch_ready_o : q1.fetch_ready_o), 32'(acc));
    if (acc) begin
      if (w == 0) exp0.push_back(e);
      else        exp1.push_back(e);
    end
    @(posedge clk); #1;
    if (w == 0) q0.fetch_valid_i = 1'b0;
    else        q1.fetch_valid_i = 1'b0;
  endtask

  task automatic wait_empty(int budget);
    for (int i = 0; i < budget && (exp0.size() + exp1.size()) > 0; i++) @(negedge clk);
    chk("drain pending", 32'(exp0.size() + exp1.size()), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("count after drain", 32'(cnt0), 32'd0);
    chk("valid after drain", 32'(q0.dec_valid_o), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    q0.fetch_valid_i = 1'b0; q0.fetch_instr_i = '0; q0.fetch_pc_i = '0; q0.dec_ready_i = 1'b0;
    q1.fetch_valid_i = 1'b0; q1.fetch_instr_i = '0; q1.fetch_pc_i = '0; q1.dec_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset count", 32'(cnt0), 32'd0);
    chk("reset valid", 32'(q0.dec_valid_o), 32'd0);
    chk("reset ready", 32'(q0.fetch_ready_o), 32'd1);
    chk("reset count dut1", 32'(cnt1), 32'd0);
    @(posedge clk); #1;

    // Decode table on the fully-enabled instance, streaming with decode always ready.
    q0.dec_ready_i = 1'b1;
    offer(0, 32'hFFF00093, 32'h1000, 32'hFFFFFFFF, 4'd0, 1'b0, 1'b1); // addi -1
    offer(0, 32'hFE000EE3, 32'h1004, 32'hFFFFFFFC, 4'd2, 1'b0, 1'b1); // beq -4
    offer(0, 32'h022081B3, 32'h1008, 32'h00000000, 4'd1, 1'b0, 1'b1); // mul
    offer(0, 32'h123452B7, 32'h100C, 32'h12345000, 4'd0, 1'b0, 1'b1); // lui
    offer(0, 32'h80000097, 32'h1010, 32'h80000000, 4'd0, 1'b0, 1'b1); // auipc
    offer(0, 32'h008000EF, 32'h1014, 32'h00000008, 4'd3, 1'b0, 1'b1); // jal +8
    offer(0, 32'hFF9FF06F, 32'h1018, 32'hFFFFFFF8, 4'd3, 1'b0, 1'b1); // jal -8
    offer(0, 32'hFFC08067, 32'h101C, 32'hFFFFFFFC, 4'd3, 1'b0, 1'b1); // jalr -4
    offer(0, 32'hFF812183, 32'h1020, 32'hFFFFFFF8, 4'd4, 1'b0, 1'b1); // lw -8
    offer(0, 32'h00512623, 32'h1024, 32'h0000000C, 4'd5, 1'b0, 1'b1); // sw 12
    offer(0, 32'hFE512E23, 32'h1028, 32'hFFFFFFFC, 4'd5, 1'b0, 1'b1); // sw -4
    offer(0, 32'h403100B3, 32'h102C, 32'h00000000, 4'd0, 1'b0, 1'b1); // sub
    offer(0, 32'h403150B3, 32'h1030, 32'h00000000, 4'd0, 1'b0, 1'b1); // sra
    offer(0, 32'h403110B3, 32'h1034, 32'h00000000, 4'd9, 1'b1, 1'b1); // alt funct7, funct3=1
    offer(0, 32'h043100B3, 32'h1038, 32'h00000000, 4'd9, 1'b1, 1'b1); // unknown funct7
    offer(0, 32'hFFFFFFFF, 32'h103C, 32'h00000000, 4'd9, 1'b1, 1'b1); // unknown opcode
    offer(0, 32'h00000073, 32'h1040, 32'h00000000, 4'd6, 1'b0, 1'b1); // ecall
    offer(0, 32'h0FF0000F, 32'h1044, 32'h000000FF, 4'd6, 1'b0, 1'b1); // fence
    offer(0, 32'h00412087, 32'h1048, 32'h00000004, 4'd7, 1'b0, 1'b1); // flw 4
    offer(0, 32'h00112427, 32'h104C, 32'h00000008, 4'd7, 1'b0, 1'b1); // fsw 8
    offer(0, 32'h002081D3, 32'h1050, 32'h00000000, 4'd8, 1'b0, 1'b1); // fadd.s
    offer(0, 32'h00000043, 32'h1054, 32'h00000000, 4'd8, 1'b0, 1'b1); // fmadd.s
    wait_empty(20);

    // M and F disabled: those opcodes become illegal, base ISA unaffected.
    q1.dec_ready_i = 1'b1;
    offer(1, 32'h022081B3, 32'h1100, 32'h00000000, 4'd9, 1'b1, 1'b1); // mul
    offer(1, 32'h00412087, 32'h1104, 32'h00000004, 4'd9, 1'b1, 1'b1); // flw
    offer(1, 32'h002081D3, 32'h1108, 32'h00000000, 4'd9, 1'b1, 1'b1); // fadd.s
    offer(1, 32'hFFF00093, 32'h110C, 32'hFFFFFFFF, 4'd0, 1'b0, 1'b1); // addi
    offer(1, 32'hFE000EE3, 32'h1110, 32'hFFFFFFFC, 4'd2, 1'b0, 1'b1); // beq
    wait_empty(20);

    // Fill under backpressure: six offers, only four fit.
    q0.dec_ready_i = 1'b0;
    for (int k = 0; k < 6; k++)
      offer(0, (32'(k) << 20) | 32'h93, 32'h2000 + 32'(4*k), 32'(k), 4'd0, 1'b0, k < 4);
    @(negedge clk);
    chk("full count", 32'(cnt0), 32'd4);
    chk("full ready", 32'(q0.fetch_ready_o), 32'd0);
    chk("full head pc held", q0.dec_pc_o, 32'h2000);
    @(posedge clk); #1;
    q0.dec_ready_i = 1'b1;
    wait_empty(20);

    // Steady state at two entries: push and pop every cycle across pointer wrap.
    q0.dec_ready_i = 1'b0;
    for (int k = 0; k < 2; k++)
      offer(0, (32'(k + 16) << 20) | 32'h93, 32'h3000 + 32'(4*k), 32'(k + 16), 4'd0, 1'b0, 1'b1);
    q0.dec_ready_i = 1'b1;
    for (int k = 2; k < 12; k++) begin
      offer(0, (32'(k + 16) << 20) | 32'h93, 32'h3000 + 32'(4*k), 32'(k + 16), 4'd0, 1'b0, 1'b1);
      chk("steady count", 32'(cnt0), 32'd2);
    end
    wait_empty(20);

    // Flush with three queued and a same-cycle offer.
    q0.dec_ready_i = 1'b0;
    for (int k = 0; k < 3; k++)
      offer(0, 32'hFFF00093, 32'h4000 + 32'(4*k), 32'hFFFFFFFF, 4'd0, 1'b0, 1'b1);
    flush = 1'b1;
    q0.fetch_valid_i = 1'b1; q0.fetch_instr_i = 32'h123452B7; q0.fetch_pc_i = 32'h4FFC;
    @(negedge clk);
    exp0.delete();
    @(posedge clk); #1;
    flush = 1'b0; q0.fetch_valid_i = 1'b0;
    @(negedge clk);
    chk("flush count", 32'(cnt0), 32'd0);
    chk("flush valid", 32'(q0.dec_valid_o), 32'd0);
    chk("flush ready", 32'(q0.fetch_ready_o), 32'd1);
    @(posedge clk); #1;
    q0.dec_ready_i = 1'b1;
    offer(0, 32'h00512623, 32'h4100, 32'h0000000C, 4'd5, 1'b0, 1'b1);
    wait_empty(20);

    // Reset mid-stream with push and pop both requested.
    q0.dec_ready_i = 1'b0;
    for (int k = 0; k < 3; k++)
      offer(0, 32'h008000EF, 32'h5000 + 32'(4*k), 32'h00000008, 4'd3, 1'b0, 1'b1);
    rst = 1'b1;
    q0.fetch_valid_i = 1'b1; q0.fetch_instr_i = 32'hFFF00093; q0.fetch_pc_i = 32'h5FFC;
    q0.dec_ready_i = 1'b1;
    @(negedge clk);
    exp0.delete();
    @(posedge clk); #1;
    rst = 1'b0; q0.fetch_valid_i = 1'b0;
    @(negedge clk);
    chk("rst count", 32'(cnt0), 32'd0);
    chk("rst valid", 32'(q0.dec_valid_o), 32'd0);
    chk("rst ready", 32'(q0.fetch_ready_o), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst stays empty", 32'(cnt0), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_predecode_queue.md
INSTR_PREDECODE_QUEUE -- requirements
Module: instr_predecode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-002 SHALL have parameter ENABLE_M, default 1, meaning RV32M opcodes are legal.
REQ-003 SHALL have parameter ENABLE_F, default 1, meaning RV32F opcodes are legal.
REQ-004 SHALL have port clk_i  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush_i  input  1  discard all queued entries.
REQ-007 SHALL have port fetch_valid_i  input  1  fetch offers an instruction.
REQ-008 SHALL have port fetch_ready_o  output  1  queue can accept.
REQ-009 SHALL have port fetch_instr_i  input  32  instruction word, instruction_t.
REQ-010 SHALL have port fetch_pc_i  input  32  address of fetch_instr_i.
REQ-011 SHALL have port dec_valid_o  output  1  head entry valid.
REQ-012 SHALL have port dec_ready_i  input  1  decode stage consumes head.
REQ-013 SHALL have port dec_instr_o  output  32  head instruction word, instruction_t.
REQ-014 SHALL have port dec_pc_o  output  32  head PC.
REQ-015 SHALL have port dec_imm_o  output  32  head sign-extended immediate.
REQ-016 SHALL have port dec_class_o  output  4  head class, dec_class_e.
REQ-017 SHALL have port dec_illegal_o  output  1  head is an illegal instruction.
REQ-018 SHALL have port count_o  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-019 Push SHALL occur when fetch_valid_i && fetch_ready_o && !flush_i; pop when dec_valid_o && dec_ready_i && !flush_i.
REQ-020 fetch_ready_o SHALL equal (count_o != DEPTH); no push when full even if popping same cycle.
REQ-021 Pushed word SHALL be predecoded combinationally and stored with PC; earliest appearance at head is the cycle after push (1-cycle latency, no bypass).
REQ-022 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-023 Outputs dec_* SHALL be driven from head entry; dec_* other than dec_valid_o are don't-care when empty but SHALL be stable while dec_valid_o && !dec_ready_i.
REQ-024 flush_i SHALL zero count and pointers next cycle, overriding same-cycle push and pop.
REQ-025 Class SHALL be: LUI/AUIPC/ALU_I/REG_OP(funct7 A_F7_I/B_F7_I) -> CLS_ALU; REG_OP F7_M -> CLS_MULDIV; BRANCH -> CLS_BRANCH; JAL/JALR -> CLS_JUMP; LOAD -> CLS_LOAD; STORE -> CLS_STORE; FENCE_O/ECSR -> CLS_SYSTEM; FLOAD/FSTORE -> CLS_FMEM; FMADD..F_OPS -> CLS_FPU; else CLS_ILLEGAL.
REQ-026 Illegal SHALL be set for: unknown opcode; REG_OP funct7 outside {A_F7_I,B_F7_I,F7_M}; REG_OP B_F7_I with funct3 not SUM/SR; F7_M with ENABLE_M=0; any RV32F opcode with ENABLE_F=0; illegal implies class CLS_ILLEGAL.
REQ-027 Immediate SHALL be I-format for LOAD/ALU_I/JALR/FLOAD/ECSR/FENCE_O, S for STORE/FSTORE, B for BRANCH, U (imm<<12) for LUI/AUIPC, J for JAL, zero otherwise; all sign-extended from bit 31.

Reset
REQ-028 With rst_i high at a clock edge, count_o, pointers SHALL be 0 and dec_valid_o 0, fetch_ready_o 1 the following cycle; rst_i overrides flush_i, push and pop.
REQ-029 Storage array SHALL not require reset; reset mid-stream SHALL drop all entries without emitting any.

Structure
REQ-030 dec_class_e (4-bit enum) and the predecoded entry struct (instr, pc, imm, class, illegal) SHALL be added to package INSTRUCTION_TYPE.
REQ-031 Predecode SHALL be a combinational sub-module instr_predecoder with ENABLE_M/ENABLE_F parameters; queue control stays in instr_predecode_queue.

Verification
REQ-032 Push 0xFFF00093 (ADDI x1,x0,-1) -> next cycle dec_valid_o=1, class CLS_ALU, imm 0xFFFFFFFF, illegal 0.
REQ-033 Push 0xFE000EE3 (BEQ x0,x0,-4) -> class CLS_BRANCH, imm 0xFFFFFFFC; push 0x022081B3 (MUL) with ENABLE_M=0 -> illegal 1, class CLS_ILLEGAL.
REQ-034 DEPTH=4, dec_ready_i=0, 6 back-to-back offers -> exactly 4 accepted, count_o=4, fetch_ready_o=0; then dec_ready_i=1 -> entries pop in order with PCs intact.
REQ-035 count=2, push and pop same cycle for 10 cycles -> count stays 2, FIFO order preserved across pointer wrap.
REQ-036 count=3, flush_i with fetch_valid_i=1 -> next cycle count_o=0, dec_valid_o=0, offered word not stored.
REQ-037 rst_i asserted with count=3 and push/pop active -> next cycle count_o=0, dec_valid_o=0, fetch_ready_o=1.
